// File: rtl/opcode_decode_pkg.sv
// rtl/opcode_decode_pkg.sv - control indices, opcode values and decode function for opcode_decode_stage
package opcode_decode_pkg;

  localparam int NUM_CTRL = 26;

  localparam int CTRL_NOOP        = 0;
  localparam int CTRL_INPUTC      = 1;
  localparam int CTRL_INPUTCF     = 2;
  localparam int CTRL_INPUTD      = 3;
  localparam int CTRL_INPUTDF     = 4;
  localparam int CTRL_MOVE        = 5;
  localparam int CTRL_LOADI_LOADP = 6;
  localparam int CTRL_ADD         = 7;
  localparam int CTRL_ADDI        = 8;
  localparam int CTRL_SUB         = 9;
  localparam int CTRL_SUBI        = 10;
  localparam int CTRL_LOAD        = 11;
  localparam int CTRL_LOADF       = 12;
  localparam int CTRL_STORE       = 13;
  localparam int CTRL_STOREF      = 14;
  localparam int CTRL_SHIFTL      = 15;
  localparam int CTRL_SHIFTR      = 16;
  localparam int CTRL_CMP         = 17;
  localparam int CTRL_JUMP        = 18;
  localparam int CTRL_BRE_BRZ     = 19;
  localparam int CTRL_BRNE_BRNZ   = 20;
  localparam int CTRL_BRG         = 21;
  localparam int CTRL_BRGE        = 22;
  // Indices 23..25 are reserved control lines and are never asserted.

  localparam logic [3:0] OP_NOOP        = 4'd0;
  localparam logic [3:0] OP_INPUT       = 4'd1;
  localparam logic [3:0] OP_MOVE        = 4'd2;
  localparam logic [3:0] OP_LOADI_LOADP = 4'd3;
  localparam logic [3:0] OP_ADD         = 4'd4;
  localparam logic [3:0] OP_ADDI        = 4'd5;
  localparam logic [3:0] OP_SUB         = 4'd6;
  localparam logic [3:0] OP_SUBI        = 4'd7;
  localparam logic [3:0] OP_LOAD        = 4'd8;
  localparam logic [3:0] OP_LOADF       = 4'd9;
  localparam logic [3:0] OP_STORE       = 4'd10;
  localparam logic [3:0] OP_STOREF      = 4'd11;
  localparam logic [3:0] OP_SHIFT       = 4'd12;
  localparam logic [3:0] OP_CMP         = 4'd13;
  localparam logic [3:0] OP_JUMP        = 4'd14;
  localparam logic [3:0] OP_BRANCH      = 4'd15;

  // Returns {illegal, ctrl}; op_ovf flags an opcode field wider than 4 bits holding a value above 15.
  function automatic logic [NUM_CTRL:0] decode_op(input logic op_ovf, input logic [3:0] op,
                                                  input logic [1:0] y);
    logic [NUM_CTRL-1:0] ctrl;
    logic                illegal;
    ctrl    = '0;
    illegal = 1'b0;
    case (op)
      OP_NOOP:        ctrl[CTRL_NOOP] = 1'b1;
      OP_INPUT: begin
        case (y)
          2'd0:    ctrl[CTRL_INPUTC]  = 1'b1;
          2'd1:    ctrl[CTRL_INPUTCF] = 1'b1;
          2'd2:    ctrl[CTRL_INPUTD]  = 1'b1;
          default: ctrl[CTRL_INPUTDF] = 1'b1;
        endcase
      end
      OP_MOVE:        ctrl[CTRL_MOVE]        = 1'b1;
      OP_LOADI_LOADP: ctrl[CTRL_LOADI_LOADP] = 1'b1;
      OP_ADD:         ctrl[CTRL_ADD]         = 1'b1;
      OP_ADDI:        ctrl[CTRL_ADDI]        = 1'b1;
      OP_SUB:         ctrl[CTRL_SUB]         = 1'b1;
      OP_SUBI:        ctrl[CTRL_SUBI]        = 1'b1;
      OP_LOAD:        ctrl[CTRL_LOAD]        = 1'b1;
      OP_LOADF:       ctrl[CTRL_LOADF]       = 1'b1;
      OP_STORE:       ctrl[CTRL_STORE]       = 1'b1;
      OP_STOREF:      ctrl[CTRL_STOREF]      = 1'b1;
      OP_SHIFT: begin
        if (y[1])      illegal             = 1'b1;
        else if (y[0]) ctrl[CTRL_SHIFTR]   = 1'b1;
        else           ctrl[CTRL_SHIFTL]   = 1'b1;
      end
      OP_CMP:         ctrl[CTRL_CMP]         = 1'b1;
      OP_JUMP:        ctrl[CTRL_JUMP]        = 1'b1;
      OP_BRANCH: begin
        case (y)
          2'd0:    ctrl[CTRL_BRE_BRZ]   = 1'b1;
          2'd1:    ctrl[CTRL_BRNE_BRNZ] = 1'b1;
          2'd2:    ctrl[CTRL_BRG]       = 1'b1;
          default: ctrl[CTRL_BRGE]      = 1'b1;
        endcase
      end
      default:        illegal = 1'b1;
    endcase
    if (op_ovf) begin
      ctrl    = '0;
      illegal = 1'b1;
    end
    return {illegal, ctrl};
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// rtl/decode_skid_buf.sv - generic 2-entry skid buffer (output register + skid register) with flush
module decode_skid_buf #(
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [PW-1:0] out_data_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic [PW-1:0] skid_data_q, skid_data_d;
  logic          accept, transfer;

  // Ready depends only on registered occupancy, so it never combinationally follows out_ready_i.
  assign in_ready_o  = (state_q != ST_FULL) & ~flush_i;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = out_data_q;
  assign accept      = in_valid_i & in_ready_o;
  assign transfer    = out_valid_o & out_ready_i;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_data_d = in_data_i;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && transfer) begin
            out_data_d = in_data_i;
          end else if (accept) begin
            skid_data_d = in_data_i;
            state_d     = ST_FULL;
          end else if (transfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (transfer) begin
            out_data_d = skid_data_q;
            state_d    = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/opcode_decode_stage.sv
// rtl/opcode_decode_stage.sv - registered i281 opcode decode stage with skid buffer; OPCODE_DECODE_PERF_EN adds perf counters
module opcode_decode_stage
  import opcode_decode_pkg::*;
#(
  parameter int IWIDTH = 16,
  parameter int OPW    = 4,
  parameter int REGW   = 2
) (
  input  logic                         CLOCK,
  input  logic                         RESET_N,
  input  logic                         FLUSH,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [IWIDTH-1:0]            IN_INSTR,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [NUM_CTRL-1:0]          OUT_CTRL,
  output logic [REGW-1:0]              OUT_X,
  output logic [REGW-1:0]              OUT_Y,
  output logic [IWIDTH-OPW-2*REGW-1:0] OUT_IMM,
  output logic                         OUT_ILLEGAL
`ifdef OPCODE_DECODE_PERF_EN
  ,
  output logic [15:0]                  PERF_RETIRED,
  output logic [15:0]                  PERF_STALL
`endif
);

  localparam int IMMW = IWIDTH - OPW - 2 * REGW;
  localparam int PW   = 1 + NUM_CTRL + 2 * REGW + IMMW;

  logic [OPW-1:0]    opcode;
  logic [REGW-1:0]   x_f, y_f;
  logic [IMMW-1:0]   imm_f;
  logic              op_ovf;
  logic [NUM_CTRL:0] dec;
  logic [PW-1:0]     in_payload, out_payload;

  assign opcode = IN_INSTR[IWIDTH-1 -: OPW];
  assign x_f    = IN_INSTR[IWIDTH-OPW-1 -: REGW];
  assign y_f    = IN_INSTR[IWIDTH-OPW-REGW-1 -: REGW];
  assign imm_f  = IN_INSTR[IMMW-1:0];
  assign op_ovf = 32'(opcode) > 32'd15;
  assign dec    = decode_op(op_ovf, opcode[3:0], y_f[1:0]);

  // Payload layout matches the output port order: {illegal, ctrl, x, y, imm}.
  assign in_payload = {dec, x_f, y_f, imm_f};

  decode_skid_buf #(
    .PW(PW)
  ) u_skid (
    .clk_i      (CLOCK),
    .rst_ni     (RESET_N),
    .flush_i    (FLUSH),
    .in_valid_i (IN_VALID),
    .in_ready_o (IN_READY),
    .in_data_i  (in_payload),
    .out_valid_o(OUT_VALID),
    .out_ready_i(OUT_READY),
    .out_data_o (out_payload)
  );

  assign {OUT_ILLEGAL, OUT_CTRL, OUT_X, OUT_Y, OUT_IMM} = out_payload;

`ifdef OPCODE_DECODE_PERF_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] stall_q, stall_d;

  // Counters observe the handshake only, so FLUSH leaves them untouched; 16-bit add wraps naturally.
  always_comb begin
    retired_d = retired_q + 16'(OUT_VALID & OUT_READY);
    stall_d   = stall_q + 16'(OUT_VALID & ~OUT_READY);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign PERF_RETIRED = retired_q;
  assign PERF_STALL   = stall_q;
`endif

endmodule

// File: tb/tb_opcode_decode_stage.sv
// tb/tb_opcode_decode_stage.sv - scoreboard bench for opcode_decode_stage
module tb_opcode_decode_stage;
  import opcode_decode_pkg::*;

  localparam int EW = 1 + NUM_CTRL + 2 + 2 + 8;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic          CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          FLUSH = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          OUT_READY = 1'b0;
  logic [15:0]   IN_INSTR = 16'h0;
  logic          IN_READY, OUT_VALID, OUT_ILLEGAL;
  logic [NUM_CTRL-1:0] OUT_CTRL;
  logic [1:0]    OUT_X, OUT_Y;
  logic [7:0]    OUT_IMM;
`ifdef OPCODE_DECODE_PERF_EN
  logic [15:0]   PERF_RETIRED, PERF_STALL;
`endif

  logic [EW-1:0] sb_q[$];
  chk_t          chk_q[$];
  chk_t          cur;
  logic [EW-1:0] got, want;
  int            tests = 0;
  int            fails = 0;
  int            w, tot;
  int            strm_idx[16] = '{CTRL_NOOP, CTRL_INPUTC, CTRL_MOVE, CTRL_LOADI_LOADP, CTRL_ADD,
                                  CTRL_ADDI, CTRL_SUB, CTRL_SUBI, CTRL_LOAD, CTRL_LOADF,
                                  CTRL_STORE, CTRL_STOREF, CTRL_SHIFTL, CTRL_CMP, CTRL_JUMP,
                                  CTRL_BRE_BRZ};

  opcode_decode_stage #(.IWIDTH(16), .OPW(4), .REGW(2)) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .FLUSH      (FLUSH),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_INSTR   (IN_INSTR),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_CTRL   (OUT_CTRL),
    .OUT_X      (OUT_X),
    .OUT_Y      (OUT_Y),
    .OUT_IMM    (OUT_IMM),
    .OUT_ILLEGAL(OUT_ILLEGAL)
`ifdef OPCODE_DECODE_PERF_EN
    ,
    .PERF_RETIRED(PERF_RETIRED),
    .PERF_STALL  (PERF_STALL)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [EW-1:0] ex(input int idx, input logic [1:0] x, input logic [1:0] y,
                                       input logic [7:0] imm);
    logic [NUM_CTRL-1:0] c;
    c = '0;
    if (idx >= 0) c[idx] = 1'b1;
    return {(idx < 0), c, x, y, imm};
  endfunction

  function automatic logic [EW-1:0] out_now();
    return {OUT_ILLEGAL, OUT_CTRL, OUT_X, OUT_Y, OUT_IMM};
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    chk_q.push_back('{n, a, e});
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input logic [15:0] word, input logic [EW-1:0] e, output int waits);
    waits    = 0;
    IN_VALID = 1'b1;
    IN_INSTR = word;
    @(negedge CLOCK);
    while (!IN_READY && waits < 40) begin
      @(negedge CLOCK);
      waits++;
    end
    if (waits == 40) chk("send_timeout", 64'(IN_READY), 64'd1);
    else sb_q.push_back(e);
    @(posedge CLOCK);
    #1;
    IN_VALID = 1'b0;
  endtask

  // Monitor: drains direct checks and compares every output transfer against the scoreboard.
  initial begin
    forever begin
      @(negedge CLOCK);
      while (chk_q.size() > 0) begin
        cur = chk_q.pop_front();
        tests++;
        if (cur.act !== cur.exp) begin
          fails++;
          $display("FAIL %s: got %0h, expected %0h", cur.name, cur.act, cur.exp);
        end
      end
      if (RESET_N && OUT_VALID && OUT_READY) begin
        got = out_now();
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got %0h, expected no output", got);
        end else begin
          want = sb_q.pop_front();
          if (got !== want) begin
            fails++;
            $display("FAIL sb_out: got %0h, expected %0h", got, want);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_payload", 64'(out_now()), 64'd0);
    @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    @(negedge CLOCK);
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    tick();

    OUT_READY = 1'b1;
    send(16'h4600, ex(CTRL_ADD, 2'd1, 2'd2, 8'h00), w);
    @(negedge CLOCK);
    chk("latency_valid", 64'(OUT_VALID), 64'd1);
    tick();

    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send({4'(i), 4'b0000, 8'(i)}, ex(strm_idx[i], 2'd0, 2'd0, 8'(i)), w);
      tot += w;
    end
    chk("stream_waits", 64'(tot), 64'd0);
    tick();
    tick();

    OUT_READY = 1'b0;
    send(16'h2512, ex(CTRL_MOVE, 2'd1, 2'd1, 8'h12), w);
    send(16'h5A34, ex(CTRL_ADDI, 2'd2, 2'd2, 8'h34), w);
    IN_VALID = 1'b1;
    IN_INSTR = 16'h6F56;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      chk("stall_in_ready", 64'(IN_READY), 64'd0);
      chk("stall_valid", 64'(OUT_VALID), 64'd1);
      chk("stall_hold", 64'(out_now()), 64'(ex(CTRL_MOVE, 2'd1, 2'd1, 8'h12)));
      tick();
    end
    OUT_READY = 1'b1;
    send(16'h6F56, ex(CTRL_SUB, 2'd3, 2'd3, 8'h56), w);
    tick();
    tick();

    send(16'hC200, ex(-1, 2'd0, 2'd2, 8'h00), w);
    send(16'hF300, ex(CTRL_BRGE, 2'd0, 2'd3, 8'h00), w);
    send(16'h1100, ex(CTRL_INPUTCF, 2'd0, 2'd1, 8'h00), w);
    send(16'hC500, ex(CTRL_SHIFTR, 2'd1, 2'd1, 8'h00), w);
    send(16'h1E00, ex(CTRL_INPUTD, 2'd3, 2'd2, 8'h00), w);
    send(16'hFE09, ex(CTRL_BRG, 2'd3, 2'd2, 8'h09), w);
    send(16'hF100, ex(CTRL_BRNE_BRNZ, 2'd0, 2'd1, 8'h00), w);
    send(16'h1300, ex(CTRL_INPUTDF, 2'd0, 2'd3, 8'h00), w);
    send(16'hCF00, ex(-1, 2'd3, 2'd3, 8'h00), w);
    tick();
    tick();

    OUT_READY = 1'b0;
    send(16'h8A01, ex(CTRL_LOAD, 2'd2, 2'd2, 8'h01), w);
    send(16'h9B02, ex(CTRL_LOADF, 2'd2, 2'd3, 8'h02), w);
    FLUSH    = 1'b1;
    IN_VALID = 1'b1;
    IN_INSTR = 16'h0000;
    @(negedge CLOCK);
    chk("flush_in_ready", 64'(IN_READY), 64'd0);
    tick();
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    sb_q.delete();
    @(negedge CLOCK);
    chk("flush_out_valid", 64'(OUT_VALID), 64'd0);
    chk("flush_in_ready_after", 64'(IN_READY), 64'd1);
    tick();

    send(16'hA4C3, ex(CTRL_STORE, 2'd1, 2'd0, 8'hC3), w);
    send(16'h3E77, ex(CTRL_LOADI_LOADP, 2'd3, 2'd2, 8'h77), w);
    OUT_READY = 1'b1;
    FLUSH     = 1'b1;
    tick();
    FLUSH = 1'b0;
    sb_q.delete();
    @(negedge CLOCK);
    chk("flush_xfer_out_valid", 64'(OUT_VALID), 64'd0);
    tick();
    send(16'hD700, ex(CTRL_CMP, 2'd1, 2'd3, 8'h00), w);
    tick();
    tick();

    OUT_READY = 1'b0;
    send(16'hE123, ex(CTRL_JUMP, 2'd0, 2'd1, 8'h23), w);
    send(16'h7C45, ex(CTRL_SUBI, 2'd3, 2'd0, 8'h45), w);
    @(negedge CLOCK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_valid", 64'(OUT_VALID), 64'd0);
    chk("async_rst_payload", 64'(out_now()), 64'd0);
    sb_q.delete();
    tick();
    RESET_N = 1'b1;
    @(negedge CLOCK);
    chk("post_rst_in_ready", 64'(IN_READY), 64'd1);
    chk("post_rst_out_valid", 64'(OUT_VALID), 64'd0);
`ifdef OPCODE_DECODE_PERF_EN
    chk("perf_retired_rst", 64'(PERF_RETIRED), 64'd0);
    chk("perf_stall_rst", 64'(PERF_STALL), 64'd0);
`endif
    tick();
    OUT_READY = 1'b1;
    send(16'hB3FF, ex(CTRL_STOREF, 2'd0, 2'd3, 8'hFF), w);
    tick();
    tick();
    @(negedge CLOCK);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
`ifdef OPCODE_DECODE_PERF_EN
    chk("perf_retired_one", 64'(PERF_RETIRED), 64'd1);
    chk("perf_stall_zero", 64'(PERF_STALL), 64'd0);
`endif
    @(negedge CLOCK);
    @(negedge CLOCK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/opcode_decode_stage.md
Name: opcode_decode_stage

Overview:
- Registered, flow-controlled successor to the combinational i281 opcode decoder.
- Accepts instruction words through a valid/ready handshake and decodes them into a one-hot control vector plus X, Y and immediate fields.
- Presents the result on a registered output with a 2-entry skid buffer.
- Sits between instruction fetch and the control/datapath; supports pipeline flush on taken branch/jump.

Parameters:
- IWIDTH, 16, instruction word width; must be > OPW + 2*REGW.
- OPW, 4, opcode field width (MSBs of word); opcode values above 15 decode as ILLEGAL.
- REGW, 2, width of X and Y register fields; must be >= 2.

Ports:
- CLOCK  input  1  single clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- FLUSH  input  1  synchronous drop of all held entries.
- IN_VALID  input  1  instruction word valid.
- IN_READY  output  1  stage can accept a word.
- IN_INSTR  input  IWIDTH  instruction word: [opcode | X | Y | IMM].
- OUT_VALID  output  1  decoded entry valid.
- OUT_READY  input  1  downstream accepts entry.
- OUT_CTRL  output  NUM_CTRL (26)  one-hot control vector, index constants in package.
- OUT_X  output  REGW  X field.
- OUT_Y  output  REGW  Y field.
- OUT_IMM  output  IWIDTH-OPW-2*REGW  immediate field.
- OUT_ILLEGAL  output  1  entry is an undefined encoding.

Behaviour:
- Reset (async, RESET_N=0):
  - OUT_VALID=0, OUT_CTRL=0, OUT_X/OUT_Y/OUT_IMM=0, OUT_ILLEGAL=0.
  - Skid buffer empty; IN_READY=1 once released.
- Decode (combinational on IN_INSTR, captured at accept):
  - Opcode 0 NOOP, 2 MOVE, 3 LOADI_LOADP, 4 ADD, 5 ADDI, 6 SUB, 7 SUBI, 8 LOAD, 9 LOADF, 10 STORE, 11 STOREF, 13 CMP, 14 JUMP.
  - Opcode 1: Y[1:0] selects INPUTC/INPUTCF/INPUTD/INPUTDF.
  - Opcode 12: Y[0] selects SHIFTL/SHIFTR. Y[1]=1 sets ILLEGAL, CTRL=0.
  - Opcode 15: Y[1:0] selects BRE_BRZ/BRNE_BRNZ/BRG/BRGE.
  - Y bits above [1:0] are ignored for sub-decode.
  - Exactly one CTRL bit is set unless ILLEGAL; an ILLEGAL entry has CTRL=0 and still flows.
- Handshake:
  - Accept when IN_VALID & IN_READY.
  - Transfer out when OUT_VALID & OUT_READY.
  - IN_READY = ~skid_full & ~FLUSH. It is registered on skid_full; FLUSH forces it low in the same cycle.
  - Latency is 1 cycle: a word accepted in cycle N is on OUT_* with OUT_VALID=1 in cycle N+1.
  - Full throughput with OUT_READY=1.
  - While OUT_VALID=1 and OUT_READY=0, OUT_* hold stable.
- States (occupancy):
  - EMPTY:
    - accept -> ONE.
  - ONE (output reg valid):
    - accept & transfer -> ONE (output reg reloaded).
    - accept & ~transfer -> FULL (word into skid).
    - ~accept & transfer -> EMPTY.
  - FULL (output + skid valid, IN_READY=0):
    - transfer -> ONE (skid moves to output reg, next cycle).
    - otherwise hold.
- FLUSH:
  - Any state -> EMPTY next cycle; OUT_VALID=0 next cycle.
  - A same-cycle downstream transfer still completes.
  - No input is accepted in the flush cycle.
- Reset mid-operation discards all entries immediately.
- Ordering is strictly FIFO; no entry is duplicated or dropped except by FLUSH or reset.

Optional Feature:
- Macro: OPCODE_DECODE_PERF_EN.
- With the macro defined, two extra output ports are added:
  - PERF_RETIRED (16): count of output transfers.
  - PERF_STALL (16): count of cycles with OUT_VALID & ~OUT_READY.
- Both counters:
  - wrap at 0xFFFF -> 0;
  - reset to 0 on RESET_N;
  - are unaffected by FLUSH.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package opcode_decode_pkg holds:
  - NUM_CTRL = 26;
  - CTRL_* bit index constants, in the order NOOP..BRGE matching the list above;
  - opcode value constants OP_NOOP..OP_BRANCH;
  - a decode function returning {illegal, ctrl}.
- One sub-module, decode_skid_buf: a generic 2-entry skid buffer parametrised by payload width, with flush.
- The top module instantiates decode_skid_buf and calls the decode function on the input side.

Test Plan:
- Reset then IN_INSTR=0x4600 (ADD, X=1, Y=2) with IN_VALID=1, OUT_READY=1.
  - Next cycle: OUT_VALID=1, OUT_CTRL=1<<CTRL_ADD, X=1, Y=2, IMM=0x00.
- Stream of 16 words with opcodes 0..15 (Y=0, IMM=i), OUT_READY=1.
  - In-order one-hot outputs; opcode 1 -> INPUTC, 12 -> SHIFTL, 15 -> BRE_BRZ.
  - One per cycle, IN_READY constantly 1.
- OUT_READY=0 while feeding 3 words A, B, C.
  - A is held on the output; B is in skid; IN_READY=0 from the cycle after B is accepted; C is not accepted.
  - OUT_READY=1 -> A, B, C emerge in order, no loss.
- Word 0xC200 (shift, Y=2).
  - OUT_ILLEGAL=1, OUT_CTRL=0.
  - Word 0xF300 -> BRGE; word 0x1100 -> INPUTCF.
- FULL state, then FLUSH=1 for one cycle with OUT_READY=0.
  - Next cycle: OUT_VALID=0, IN_READY=1.
  - IN_VALID held during flush -> that word is not accepted.
- RESET_N pulsed low asynchronously mid-stream.
  - All outputs 0 immediately.
  - With OPCODE_DECODE_PERF_EN: PERF_RETIRED counts transfers, wraps after 65536, and resets to 0.
